// File: rtl/multi_blinker.sv
// Multi-channel blink generator: one shared prescaler strobe drives per-channel
// half-period counters running in OFF, SOLID, continuous-blink or counted-burst mode.
module multi_blinker #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned RATE_W   = 10,
  parameter int unsigned PRESCALE = 65536,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*RATE_W-1:0]   rate,
  input  logic [NUM_CH*2-1:0]        mode,
  input  logic [NUM_CH*CNT_W-1:0]    burst_len,
  input  logic [NUM_CH-1:0]          start,
  output logic [NUM_CH-1:0]          blink,
  output logic [NUM_CH-1:0]          busy,
  output logic                       tick
);

  localparam int unsigned PRE_W = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_CONT  = 2'b01,
    MODE_BURST = 2'b10,
    MODE_SOLID = 2'b11
  } mode_e;

  logic [PRE_W-1:0] r_pre;
  logic             r_tick;
  logic             w_pre_wrap;

  // Channels advance on the same edge that raises tick, so toggles line up with it.
  assign w_pre_wrap = (r_pre == PRE_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= w_pre_wrap ? '0 : r_pre + PRE_W'(1);
      r_tick <= w_pre_wrap;
    end
  end

  assign tick = r_tick;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    mode_e             w_mode;
    logic [RATE_W-1:0] w_rate;
    logic [CNT_W-1:0]  w_len;
    logic              w_start;

    mode_e             r_prev;
    logic [RATE_W-1:0] r_hcnt;
    logic [RATE_W-1:0] r_rate_sh;
    logic [CNT_W-1:0]  r_rem;
    logic              r_blink;
    logic              r_busy;

    assign w_mode  = mode_e'(mode[gi*2 +: 2]);
    assign w_rate  = rate[gi*RATE_W +: RATE_W];
    assign w_len   = burst_len[gi*CNT_W +: CNT_W];
    assign w_start = start[gi];

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_prev    <= MODE_OFF;
        r_hcnt    <= '0;
        r_rate_sh <= '0;
        r_rem     <= '0;
        r_blink   <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        r_prev <= w_mode;
        if (w_mode != r_prev) begin
          // Mode entry beats any start or tick in the same cycle.
          r_hcnt    <= '0;
          r_rate_sh <= w_rate;
          r_rem     <= '0;
          r_busy    <= 1'b0;
          r_blink   <= (w_mode == MODE_CONT) || (w_mode == MODE_SOLID);
        end else if (w_mode == MODE_OFF || w_mode == MODE_SOLID) begin
          r_hcnt  <= '0;
          r_rem   <= '0;
          r_busy  <= 1'b0;
          r_blink <= (w_mode == MODE_SOLID);
        end else if (w_mode == MODE_BURST && !r_busy) begin
          r_hcnt <= '0;
          if (w_start && (w_len != '0)) begin
            r_blink   <= 1'b1;
            r_busy    <= 1'b1;
            r_rem     <= w_len;
            r_rate_sh <= w_rate;
          end else begin
            r_blink <= 1'b0;
          end
        end else if (w_pre_wrap) begin
          // Rate is reloaded only at a toggle so a half-period is never cut or stretched.
          if (r_hcnt == r_rate_sh) begin
            r_hcnt    <= '0;
            r_rate_sh <= w_rate;
            r_blink   <= ~r_blink;
            if (w_mode == MODE_BURST && r_blink) begin
              r_rem <= r_rem - CNT_W'(1);
              if (r_rem == CNT_W'(1)) begin
                r_busy <= 1'b0;
              end
            end
          end else begin
            r_hcnt <= r_hcnt + RATE_W'(1);
          end
        end
      end
    end

    assign blink[gi] = r_blink;
    assign busy[gi]  = r_busy;
  end

endmodule
